// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: shares one single-port sync RAM between IF and DM.
// Define SHARED_RAM_ARB_RR_EN for round-robin tie-break (default: DM wins).
module shared_ram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wen,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_stall,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic       GNT_IF = 1'b0;
    localparam logic       GNT_DM = 1'b1;
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYC);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              grant;
    logic              grant_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]       din_nx;
    logic              cap_if;
    logic              cap_dm;
    logic              pick_dm;
    logic              start;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    assign start = (state == S_IDLE) & cpu_en & (if_req | dm_req);

`ifdef SHARED_RAM_ARB_RR_EN
    logic last_grant;

    // Ties go to whoever was not served last; a lone request always wins
    always_comb begin
        pick_dm = dm_req & (~if_req | (last_grant == GNT_IF));
    end

    // Remember the most recent grant for the next tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_IF;
        end else if (start) begin
            last_grant <= pick_dm;
        end
    end
`else
    // Fixed priority: DM always beats IF
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    // Next-state and latch values; everything holds while cpu_en is low
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant_nx = grant;
        addr_nx  = ram_addr;
        din_nx   = ram_din;
        cap_if   = 1'b0;
        cap_dm   = 1'b0;
        if (cpu_en) begin
            unique case (state)
                S_IDLE: begin
                    if (if_req | dm_req) begin
                        grant_nx = pick_dm ? GNT_DM : GNT_IF;
                        addr_nx  = pick_dm ? dm_addr[ADDR_W+1:2]
                                           : if_addr[ADDR_W+1:2];
                        din_nx   = dm_wdata;
                        cnt_nx   = '0;
                        state_nx = (pick_dm & dm_wen) ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    state_nx = S_DONE;
                end
                S_READ: begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt == WAIT_L) begin
                        cap_if   = (grant == GNT_IF);
                        cap_dm   = (grant == GNT_DM);
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Controller state, latched RAM request and captured read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            grant    <= GNT_IF;
            ram_addr <= '0;
            ram_din  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            grant    <= grant_nx;
            ram_addr <= addr_nx;
            ram_din  <= din_nx;
            if (cap_if) begin
                if_rdata <= ram_dout;
            end
            if (cap_dm) begin
                dm_rdata <= ram_dout;
            end
        end
    end

    // Write strobe and stalls are combinational so reset kills them at once
    always_comb begin
        ram_we   = (state == S_WRITE) & cpu_en;
        busy     = (state != S_IDLE);
        if_stall = if_req & ~((state == S_DONE) & (grant == GNT_IF));
        dm_stall = dm_req & ~((state == S_DONE) & (grant == GNT_DM));
    end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// tb_shared_ram_arbiter: vector table, corner sequences, random vs model.
// Covers WAIT_CYC=1 (main) and WAIT_CYC=3 (second instance).
module tb_shared_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;

    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_if_stall;
    logic [31:0] unused_b_dmrd;
    logic        unused_b_dms;
    logic        b_ram_we;
    logic [9:0]  b_ram_addr;
    logic [31:0] b_ram_din;
    logic [31:0] b_ram_dout;
    logic        b_busy;

    int total;
    int bad;

    shared_ram_arbiter #(.ADDR_W(10), .WAIT_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    shared_ram_arbiter #(.ADDR_W(10), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .cpu_en(1'b1),
        .if_req(b_if_req), .if_addr(b_if_addr),
        .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .dm_req(1'b0), .dm_wen(1'b0), .dm_addr(32'h0),
        .dm_wdata(32'h0), .dm_rdata(unused_b_dmrd), .dm_stall(unused_b_dms),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
        .ram_dout(b_ram_dout), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] finit(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // RAM for main instance: one-cycle registered read
    logic [31:0] mem_a [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem_a[ram_addr] <= ram_din;
        ram_dout <= mem_a[ram_addr];
    end

    // RAM for WAIT_CYC=3 instance: three-stage read pipeline
    logic [31:0] mem_b [0:1023];
    logic [31:0] b_p1;
    logic [31:0] b_p2;
    always @(posedge clk) begin
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
        b_p1       <= mem_b[b_ram_addr];
        b_p2       <= b_p1;
        b_ram_dout <= b_p2;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          dm;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          frz_at;
        int          frz_len;
        int          e_stall;
        int          e_busy;
        int          e_we;
        logic [9:0]  e_waddr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt [7];

    task automatic run_vec(input vec_t v, output int st, output int bz,
                           output int we, output logic [9:0] wa,
                           output logic [31:0] dat);
        st  = 0;
        bz  = 0;
        we  = 0;
        wa  = '0;
        dat = '0;
        @(negedge clk);
        if (v.dm) begin
            dm_req   = 1'b1;
            dm_wen   = v.wen;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        for (int c = 0; c < 64; c++) begin
            cpu_en = !(v.frz_len > 0 && c >= v.frz_at &&
                       c < v.frz_at + v.frz_len);
            #1;
            if (busy) begin
                bz++;
                wa = ram_addr;
            end
            if (ram_we) begin
                we++;
                dat = ram_din;
            end
            if (v.dm ? !dm_stall : !if_stall) begin
                if (!(v.dm && v.wen)) dat = v.dm ? dm_rdata : if_rdata;
                break;
            end
            st++;
            @(negedge clk);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_wen = 1'b0;
        cpu_en = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [19:0] hi;
        logic [3:0]  w;
        logic [1:0]  lo;
        hi = 20'($urandom);
        w  = 4'($urandom);
        lo = 2'($urandom);
        return {hi, 6'b000010, w, lo};
    endfunction

    logic [31:0] mm [0:1023];

    initial begin
        int          st, bz, we, n, dn, t_dm1, t_if;
        int          ord [3];
        logic [9:0]  wa;
        logic [31:0] dat;
        logic [31:0] if_seen;
        logic        if_at_dm1;
        int          bst, bbz;
        int          ek, t0, len, pos;
        bit          active, own, wrf, lastg, done, if_fin, dm_fin;
        logic [9:0]  mwa;
        logic [31:0] med;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = finit(i);
            mm[i]    = finit(i);
            mem_b[i] = 32'h11111111;
        end
        mem_a[4] = 32'hDEADBEEF;
        mem_b[5] = 32'hCAFEF00D;
        b_p1       = 32'hBAD0BAD0;
        b_p2       = 32'hBAD0BAD0;
        b_ram_dout = 32'hBAD0BAD0;

        vt[0] = '{0, 0, 32'h10,       32'h0,         0, 0, 3, 3, 0,
                  10'd4,   32'hDEADBEEF};
        vt[1] = '{1, 1, 32'h24,       32'h12345678,  0, 0, 2, 2, 1,
                  10'd9,   32'h12345678};
        vt[2] = '{1, 0, 32'h24,       32'h0,         0, 0, 3, 3, 0,
                  10'd9,   32'h12345678};
        vt[3] = '{0, 0, 32'hFFFFF027, 32'h0,         0, 0, 3, 3, 0,
                  10'd9,   32'h12345678};
        vt[4] = '{1, 1, 32'h1FFE,     32'hA5A55A5A,  1, 3, 5, 5, 1,
                  10'h3FF, 32'hA5A55A5A};
        vt[5] = '{0, 0, 32'hFFC,      32'h0,         2, 5, 8, 8, 0,
                  10'h3FF, 32'hA5A55A5A};
        vt[6] = '{1, 0, 32'h3,        32'h0,         0, 0, 3, 3, 0,
                  10'd0,   32'hC0DE0000};

        rst       = 1'b0;
        cpu_en    = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_wen    = 1'b0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        b_if_req  = 1'b0;
        b_if_addr = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk1("rst_if_stall", if_stall, 1'b1);
        chk1("rst_dm_stall", dm_stall, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_we", ram_we, 1'b0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        rst    = 1'b1;
        if_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i], st, bz, we, wa, dat);
            chki($sformatf("v%0d_stall", i), st, vt[i].e_stall);
            chki($sformatf("v%0d_busy", i), bz, vt[i].e_busy);
            chki($sformatf("v%0d_we", i), we, vt[i].e_we);
            chk($sformatf("v%0d_addr", i), 32'(wa), 32'(vt[i].e_waddr));
            chk($sformatf("v%0d_data", i), dat, vt[i].e_data);
        end

        // Async reset in the middle of a write
        @(negedge clk);
        dm_req   = 1'b1;
        dm_wen   = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'h77;
        @(negedge clk);
        #1;
        chk1("ar_we_before", ram_we, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("ar_we", ram_we, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk("ar_if_rdata", if_rdata, 32'h0);
        chk("ar_dm_rdata", dm_rdata, 32'h0);
        chk("ar_addr", 32'(ram_addr), 32'h0);
        chk1("ar_dm_stall", dm_stall, 1'b1);
        @(negedge clk);
        rst    = 1'b1;
        dm_req = 1'b0;
        dm_wen = 1'b0;

        // Ties: DM keeps re-requesting once after its first access
        @(negedge clk);
        if_req    = 1'b1;
        if_addr   = 32'h10;
        dm_req    = 1'b1;
        dm_addr   = 32'h24;
        n         = 0;
        dn        = 0;
        t_dm1     = -100;
        t_if      = 0;
        if_at_dm1 = 1'b0;
        if_seen   = '0;
        ord       = '{-1, -1, -1};
        for (int c = 0; c < 60 && n < 3; c++) begin
            #1;
            if (dm_req && !dm_stall) begin
                ord[n] = 1;
                n++;
                dn++;
                if (dn == 1) begin
                    t_dm1     = c;
                    if_at_dm1 = if_stall;
                end
                if (dn == 2) dm_req = 1'b0;
            end else if (if_req && !if_stall) begin
                ord[n]  = 0;
                n++;
                t_if    = c;
                if_seen = if_rdata;
                if_req  = 1'b0;
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        chki("tie_count", n, 3);
        chki("tie_first", ord[0], 1);
        chk1("tie_if_held", if_at_dm1, 1'b1);
        chk("tie_if_data", if_seen, 32'hDEADBEEF);
`ifdef SHARED_RAM_ARB_RR_EN
        chki("tie_second", ord[1], 0);
        chki("tie_third", ord[2], 1);
        chki("tie_if_gap", t_if - t_dm1, 4);
`else
        chki("tie_second", ord[1], 1);
        chki("tie_third", ord[2], 0);
        chki("tie_if_gap", t_if - t_dm1, 8);
`endif

        // WAIT_CYC=3 read on the second instance
        @(negedge clk);
        b_if_req  = 1'b1;
        b_if_addr = 32'h14;
        bst       = 0;
        bbz       = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (b_busy) bbz++;
            if (!b_if_stall) break;
            bst++;
            @(negedge clk);
        end
        chki("w3_stall", bst, 5);
        chki("w3_busy", bbz, 5);
        chk("w3_rdata", b_if_rdata, 32'hCAFEF00D);
        b_if_req = 1'b0;

        // Random traffic against a cycle-count model
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        active = 0;
        lastg  = 0;
        own    = 0;
        wrf    = 0;
        ek     = 0;
        t0     = 0;
        len    = 0;
        mwa    = '0;
        med    = '0;
        if_fin = 0;
        dm_fin = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req  = 1'b1;
                    if_addr = rnd_addr();
                end
            end else if (if_fin) begin
                if_fin  = 0;
                if_req  = 1'($urandom_range(0, 1));
                if_addr = rnd_addr();
            end
            if (!dm_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_req   = 1'b1;
                    dm_wen   = 1'($urandom_range(0, 1));
                    dm_addr  = rnd_addr();
                    dm_wdata = $urandom;
                end
            end else if (dm_fin) begin
                dm_fin   = 0;
                dm_req   = 1'($urandom_range(0, 1));
                dm_wen   = 1'($urandom_range(0, 1));
                dm_addr  = rnd_addr();
                dm_wdata = $urandom;
            end
            cpu_en = ($urandom_range(0, 7) != 0);
            #1;
            if (active && (ek - t0) > len) active = 0;
            pos  = ek - t0;
            done = active && (pos == len);
            chk1("r_busy", busy, active);
            chk1("r_if_stall", if_stall, if_req && !(done && own == 0));
            chk1("r_dm_stall", dm_stall, dm_req && !(done && own == 1));
            chk1("r_we", ram_we, active && wrf && pos == 1 && cpu_en);
            if (active) chk("r_addr", 32'(ram_addr), 32'(mwa));
            if (active && wrf) chk("r_din", ram_din, med);
            if (done && !wrf) chk("r_rdata", own ? dm_rdata : if_rdata, med);
            if (done && cpu_en) begin
                if (own) dm_fin = 1;
                else     if_fin = 1;
            end
            if (!active && cpu_en && (if_req || dm_req)) begin
`ifdef SHARED_RAM_ARB_RR_EN
                own = dm_req && (!if_req || lastg == 0);
`else
                own = dm_req;
`endif
                lastg  = own;
                wrf    = own && dm_wen;
                mwa    = own ? dm_addr[11:2] : if_addr[11:2];
                len    = wrf ? 2 : 1 + 2;
                t0     = ek;
                active = 1;
                if (wrf) begin
                    med     = dm_wdata;
                    mm[mwa] = dm_wdata;
                end else begin
                    med = mm[mwa];
                end
            end
            ek += int'(cpu_en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
